sync_fifo_flags: RTL

Parametrised synchronous FIFO: the next generation of the team's single-clock buffer. Adds configurable width and depth, occupancy output, programmable almost-full/almost-empty thresholds, overflow/underflow error pulses, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer stages in one clock domain and replaces the fixed 16x8 FIFO in new designs.

---
 rtl/fifo_pkg.sv | 37 +++
 rtl/fifo_mem.sv | 37 +++
 rtl/sync_fifo_flags.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO family.
// Provides address-width derivation and parameter legality predicates.
// Elaboration-time checks in the top module use these predicates.
package fifo_pkg;

  // Read-path mode selector.
  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  // Address width for a given depth.
  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // True when n is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

  // Depth must be a power of two and at least 4 entries.
  function automatic bit depth_legal(input int unsigned depth);
    return is_pow2(depth) && (depth >= 4);
  endfunction

  // Almost-full threshold must lie in 1..DEPTH.
  function automatic bit af_legal(input int unsigned depth, input int unsigned af);
    return (af >= 1) && (af <= depth);
  endfunction

  // Almost-empty threshold must lie in 0..DEPTH-1.
  function automatic bit ae_legal(input int unsigned depth, input int unsigned ae);
    return ae < depth;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage array for the synchronous FIFO.
// Ports:
//   CLK    - write clock, rising edge
//   we     - write enable (already qualified by the controller)
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - asynchronous read data, mem[raddr]
// Contents are deliberately not reset; the controller never exposes an
// unwritten entry as valid data.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       we,
  input  logic [addr_w(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [addr_w(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single synchronous write port.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read port.
  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with occupancy, threshold flags,
// overflow/underflow pulses, synchronous flush and selectable FWFT read.
// Ports:
//   CLK           - clock, rising edge
//   RST           - asynchronous active-high reset
//   CLR           - synchronous flush, overrides WEN/REN
//   WEN, D        - write request and data
//   REN           - read request (pop)
//   Q             - read data (registered, or fall-through when FWFT=1)
//   FULL, EMPTY   - COUNT == DEPTH / COUNT == 0
//   ALMOST_FULL   - COUNT >= AF_LEVEL
//   ALMOST_EMPTY  - COUNT <= AE_LEVEL
//   COUNT         - occupancy 0..DEPTH
//   OVERFLOW      - one-cycle pulse after a rejected write
//   UNDERFLOW     - one-cycle pulse after a rejected read
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4,
  parameter bit          FWFT     = 1'b0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLR,
  input  logic                     WEN,
  input  logic [WIDTH-1:0]         D,
  input  logic                     REN,
  output logic [WIDTH-1:0]         Q,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     ALMOST_FULL,
  output logic                     ALMOST_EMPTY,
  output logic [addr_w(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW
);

  localparam int unsigned ADDR  = addr_w(DEPTH);
  localparam int unsigned CNT_W = ADDR + 1;

  // Parameter legality, reported at elaboration.
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_flags: WIDTH must be at least 1");
  end
  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two and >= 4");
  end
  if (!af_legal(DEPTH, AF_LEVEL)) begin : g_bad_af
    $error("sync_fifo_flags: AF_LEVEL must be in 1..DEPTH");
  end
  if (!ae_legal(DEPTH, AE_LEVEL)) begin : g_bad_ae
    $error("sync_fifo_flags: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [ADDR-1:0]  wr_ptr;
  logic [ADDR-1:0]  rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] mem_rdata;
  logic             ovf_q;
  logic             udf_q;
  logic             full_c;
  logic             empty_c;
  logic             wr_ok;
  logic             rd_ok;

  // Flags decode straight from the registered occupancy.
  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);

  // Acceptance uses pre-edge FULL/EMPTY; a flush suppresses both.
  assign wr_ok = WEN && !full_c && !CLR;
  assign rd_ok = REN && !empty_c && !CLR;

  // Occupancy next value: simultaneous accepted write+read cancels out.
  always_comb begin
    count_nxt = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy, read register and error pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      q_reg  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (CLR) begin
      // Flush: Q keeps its last value, memory is left as is.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ADDR'(1);
        q_reg  <= mem_rdata;
      end
      count <= count_nxt;
      ovf_q <= WEN && full_c;
      udf_q <= REN && empty_c;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .CLK   (CLK),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (D),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Read data path. In FWFT mode the head entry is presented directly;
  // while empty the last popped word (or reset value) is held so Q
  // stays stable.
  if (FWFT == MODE_FWFT) begin : g_fwft
    assign Q = empty_c ? q_reg : mem_rdata;
  end else begin : g_std
    assign Q = q_reg;
  end

  assign FULL         = full_c;
  assign EMPTY        = empty_c;
  assign ALMOST_FULL  = (count >= CNT_W'(AF_LEVEL));
  assign ALMOST_EMPTY = (count <= CNT_W'(AE_LEVEL));
  assign COUNT        = count;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;

endmodule
